bus_wrr_arbiter: RTL and testbench

BUS_WRR_ARBITER -- requirements
Module: bus_wrr_arbiter

---
 rtl/bus_arb_pkg.sv | 16 +
 rtl/bus_wrr_arbiter_rr_pick.sv | 33 +++
 rtl/bus_wrr_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_bus_wrr_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the weighted round-robin bus arbiter.
//   arb_state_t : arbiter FSM states
//   DEF_*       : default values for the arbiter parameters
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        GRANT  = 2'd2
    } arb_state_t;

    localparam int DEF_DRVRS = 4;
    localparam int DEF_WGT_W = 4;
    localparam int DEF_TMO   = 16;

endpackage : bus_arb_pkg

// File: rtl/bus_wrr_arbiter_rr_pick.sv
// Combinational circular first-match search.
// Starting at index ptr (inclusive) and wrapping modulo N, returns the
// first set bit of req.
//   req   : request vector, one bit per device
//   ptr   : index where the search starts
//   idx   : index of the first set bit found (0 when none)
//   found : high when any bit of req is set
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] j;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule : rr_pick

// File: rtl/bus_wrr_arbiter.sv
// Weighted round-robin arbiter for a shared bus.
// Each device owns a credit counter loaded from its weight on REFILL; a
// grant consumes one credit when the transfer completes (or times out).
// The search pointer stays on a device while it still has credit, so a
// device with weight W gets up to W back-to-back packets per round.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   pndng     : bit i high when device i has a packet waiting
//   weight    : packed per-device weights, slice i = device i; 0 masks it
//   xfer_done : one-cycle pulse, current granted packet finished
//   gnt       : one-hot grant (or zero), registered
//   gnt_vld   : high exactly when gnt is non-zero
//   busy      : high while in REFILL or GRANT
//   err_tmo   : one-cycle pulse when a grant is force-released on timeout
module bus_wrr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int DRVRS = DEF_DRVRS,
    parameter int WGT_W = DEF_WGT_W,
    parameter int TMO   = DEF_TMO
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DRVRS-1:0]       pndng,
    input  logic [DRVRS*WGT_W-1:0] weight,
    input  logic                   xfer_done,
    output logic [DRVRS-1:0]       gnt,
    output logic                   gnt_vld,
    output logic                   busy,
    output logic                   err_tmo
);

    localparam int IW = (DRVRS > 1) ? $clog2(DRVRS) : 1;
    localparam int TW = $clog2(TMO + 1);

    arb_state_t       state, state_d;
    logic [WGT_W-1:0] credit   [DRVRS];
    logic [WGT_W-1:0] credit_d [DRVRS];
    logic [IW-1:0]    ptr, ptr_d;
    logic [IW-1:0]    gidx, gidx_d;
    logic [TW-1:0]    tmo_cnt, tmo_d;
    logic [DRVRS-1:0] gnt_d;
    logic             gnt_vld_d, busy_d, err_d;

    logic [DRVRS-1:0] elig;
    logic [DRVRS-1:0] avail;
    logic [IW-1:0]    pick_idx;
    logic             pick_found;
    logic [WGT_W-1:0] dec_credit;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == IW'(DRVRS - 1)) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [WGT_W-1:0] sat_dec(input logic [WGT_W-1:0] c);
        return (c == '0) ? '0 : c - 1'b1;
    endfunction

    // Eligible = pending with a non-zero weight; available = eligible with
    // credit left in the current round.
    always_comb begin
        elig  = '0;
        avail = '0;
        for (int i = 0; i < DRVRS; i++) begin
            elig[i]  = pndng[i] && (weight[i*WGT_W +: WGT_W] != '0);
            avail[i] = elig[i] && (credit[i] != '0);
        end
    end

    rr_pick #(
        .N  (DRVRS),
        .IW (IW)
    ) u_pick (
        .req   (avail),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign dec_credit = sat_dec(credit[gidx]);

    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        gidx_d  = gidx;
        ptr_d   = ptr;
        tmo_d   = tmo_cnt;
        err_d   = 1'b0;
        for (int i = 0; i < DRVRS; i++) begin
            credit_d[i] = credit[i];
        end

        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_d         = GRANT;
                    gidx_d          = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    tmo_d           = '0;
                end else if (|elig) begin
                    // Eligible devices exist but the round is spent.
                    state_d = REFILL;
                end
            end

            REFILL: begin
                for (int i = 0; i < DRVRS; i++) begin
                    credit_d[i] = weight[i*WGT_W +: WGT_W];
                end
                state_d = IDLE;
            end

            GRANT: begin
                // xfer_done wins over a simultaneous pndng drop.
                if (xfer_done) begin
                    credit_d[gidx] = dec_credit;
                    ptr_d          = (dec_credit != '0) ? gidx : wrap_inc(gidx);
                    state_d        = IDLE;
                    gnt_d          = '0;
                    tmo_d          = '0;
                end else if (!pndng[gidx]) begin
                    ptr_d   = wrap_inc(gidx);
                    state_d = IDLE;
                    gnt_d   = '0;
                    tmo_d   = '0;
                end else if (tmo_cnt == TW'(TMO - 1)) begin
                    // This edge closes the TMO-th grant cycle.
                    err_d          = 1'b1;
                    credit_d[gidx] = dec_credit;
                    ptr_d          = wrap_inc(gidx);
                    state_d        = IDLE;
                    gnt_d          = '0;
                    tmo_d          = '0;
                end else begin
                    tmo_d = tmo_cnt + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                tmo_d   = '0;
            end
        endcase

        gnt_vld_d = |gnt_d;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            busy    <= 1'b0;
            err_tmo <= 1'b0;
            ptr     <= '0;
            gidx    <= '0;
            tmo_cnt <= '0;
            for (int i = 0; i < DRVRS; i++) begin
                credit[i] <= '0;
            end
        end else begin
            state   <= state_d;
            gnt     <= gnt_d;
            gnt_vld <= gnt_vld_d;
            busy    <= busy_d;
            err_tmo <= err_d;
            ptr     <= ptr_d;
            gidx    <= gidx_d;
            tmo_cnt <= tmo_d;
            for (int i = 0; i < DRVRS; i++) begin
                credit[i] <= credit_d[i];
            end
        end
    end

endmodule : bus_wrr_arbiter

// File: tb/tb_bus_wrr_arbiter.sv
// Bench for bus_wrr_arbiter with DRVRS=4, WGT_W=4, TMO=16.
module tb_bus_wrr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pndng;
    logic [15:0] weight;
    logic        xfer_done;
    logic [3:0]  gnt;
    logic        gnt_vld;
    logic        busy;
    logic        err_tmo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  p;
        logic [15:0] w;
        logic        xd;
        logic [3:0]  g;
        logic        vld;
        logic        bsy;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    bus_wrr_arbiter #(
        .DRVRS (4),
        .WGT_W (4),
        .TMO   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pndng     (pndng),
        .weight    (weight),
        .xfer_done (xfer_done),
        .gnt       (gnt),
        .gnt_vld   (gnt_vld),
        .busy      (busy),
        .err_tmo   (err_tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] p, input logic [15:0] w, input logic xd,
                       input logic [3:0] g, input logic vld, input logic bsy, input logic err);
        vec_t v;
        v.p = p; v.w = w; v.xd = xd; v.g = g; v.vld = vld; v.bsy = bsy; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pndng     = '0;
        xfer_done = 1'b0;
        step();
        reset     = 1'b0;
    endtask

    int order[7] = '{0, 1, 1, 2, 2, 2, 3};
    int lat_exp[7] = '{3, 1, 1, 1, 1, 1, 1};

    initial begin
        int lat;
        reset     = 1'b1;
        pndng     = '0;
        weight    = 16'h2222;
        xfer_done = 1'b0;

        // Reset held two cycles.
        step();
        step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_vld", 32'(gnt_vld), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_tmo), 0);
        reset = 1'b0;

        //   pndng   weight    xd   gnt     vld  busy err
        add(4'b0000, 16'h2222, 0, 4'b0000, 0, 0, 0);
        add(4'b0000, 16'h2222, 0, 4'b0000, 0, 0, 0);
        add(4'b0100, 16'h2222, 0, 4'b0000, 0, 1, 0); // REFILL
        add(4'b0100, 16'h2222, 0, 4'b0000, 0, 0, 0); // back to IDLE
        add(4'b0100, 16'h2222, 0, 4'b0100, 1, 1, 0); // grant dev2
        add(4'b0100, 16'h2222, 0, 4'b0100, 1, 1, 0);
        add(4'b0100, 16'h2222, 1, 4'b0000, 0, 0, 0); // credit2 2->1
        add(4'b0100, 16'h2222, 0, 4'b0100, 1, 1, 0);
        add(4'b0100, 16'h2222, 1, 4'b0000, 0, 0, 0); // credit2 1->0
        add(4'b0100, 16'h2222, 0, 4'b0000, 0, 1, 0); // REFILL
        add(4'b0100, 16'h2222, 0, 4'b0000, 0, 0, 0);
        add(4'b0100, 16'h2222, 0, 4'b0100, 1, 1, 0);
        add(4'b0000, 16'h2222, 0, 4'b0000, 0, 0, 0); // pndng drop, credit2 stays 2
        add(4'b0000, 16'h2222, 1, 4'b0000, 0, 0, 0); // xfer_done in IDLE ignored
        add(4'b0100, 16'h2222, 0, 4'b0100, 1, 1, 0); // direct grant
        add(4'b0000, 16'h2222, 1, 4'b0000, 0, 0, 0); // xd beats drop: 2->1
        add(4'b0100, 16'h2222, 0, 4'b0100, 1, 1, 0);
        add(4'b0100, 16'h2222, 1, 4'b0000, 0, 0, 0); // 1->0
        add(4'b0100, 16'h2222, 0, 4'b0000, 0, 1, 0); // REFILL
        add(4'b0010, 16'h2202, 0, 4'b0000, 0, 0, 0); // loads weight1=0
        add(4'b0010, 16'h2202, 0, 4'b0000, 0, 0, 0);
        add(4'b0010, 16'h2202, 0, 4'b0000, 0, 0, 0);
        add(4'b0010, 16'h2202, 0, 4'b0000, 0, 0, 0);
        add(4'b0010, 16'h2202, 0, 4'b0000, 0, 0, 0);

        foreach (vecs[i]) begin
            pndng     = vecs[i].p;
            weight    = vecs[i].w;
            xfer_done = vecs[i].xd;
            step();
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].g));
            chk($sformatf("v%0d_vld", i), 32'(gnt_vld), 32'(vecs[i].vld));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
            chk($sformatf("v%0d_err", i), 32'(err_tmo), 32'(vecs[i].err));
        end
        xfer_done = 1'b0;

        // Weighted order {1,2,3,1}, two rounds.
        weight = 16'h1321;
        do_reset();
        pndng = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 7; k++) begin
                lat = 0;
                do begin
                    step();
                    lat++;
                end while (gnt == 4'b0000 && lat < 8);
                chk($sformatf("wrr_r%0d_k%0d_lat", r, k), 32'(lat), 32'(lat_exp[k]));
                chk($sformatf("wrr_r%0d_k%0d_gnt", r, k), 32'(gnt), 32'(1) << order[k]);
                step();
                chk($sformatf("wrr_r%0d_k%0d_hold", r, k), 32'(gnt), 32'(1) << order[k]);
                step();
                xfer_done = 1'b1;
                step();
                xfer_done = 1'b0;
                chk($sformatf("wrr_r%0d_k%0d_rel", r, k), 32'(gnt), 0);
            end
        end

        // Timeout on device 3, then search restarts at device 0.
        weight = 16'h2222;
        do_reset();
        pndng = 4'b1000;
        step();
        step();
        step();
        chk("tmo_gnt3", 32'(gnt), 32'h8);
        pndng = 4'b1001;
        for (int c = 0; c < 15; c++) begin
            step();
            chk($sformatf("tmo_hold%0d", c), 32'(gnt), 32'h8);
            chk($sformatf("tmo_noerr%0d", c), 32'(err_tmo), 0);
        end
        step();
        chk("tmo_err", 32'(err_tmo), 1);
        chk("tmo_gnt_clr", 32'(gnt), 0);
        chk("tmo_vld_clr", 32'(gnt_vld), 0);
        step();
        chk("tmo_err_pulse", 32'(err_tmo), 0);
        chk("tmo_next_dev0", 32'(gnt), 32'h1);

        // Drop pndng[1] while granted: no credit change, ptr moves to 2.
        weight = 16'h1111;
        do_reset();
        pndng = 4'b0010;
        step();
        step();
        step();
        chk("drop_gnt1", 32'(gnt), 32'h2);
        pndng = 4'b0000;
        step();
        chk("drop_clr", 32'(gnt), 0);
        pndng = 4'b0110;
        step();
        chk("drop_ptr2", 32'(gnt), 32'h4);
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        chk("drop_rel2", 32'(gnt), 0);
        step();
        chk("drop_credit1_kept", 32'(gnt), 32'h2);

        // Reset in the middle of a grant.
        reset = 1'b1;
        step();
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_vld", 32'(gnt_vld), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_err", 32'(err_tmo), 0);
        reset = 1'b0;
        pndng = 4'b0000;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bus_wrr_arbiter
